cpu_mem_arbiter: RTL
====================

# cpu_mem_arbiter

Two-requester arbiter for the CPU's shared single-port working memory. It sits between the CPU core's load/store/fetch port and the host loader port, which is driven from `ui_in`/`uio_in` during program download and debug. It serialises accesses with a req/gnt handshake, routes read data back with fixed latency, and protects the CPU from starvation by host traffic.

## Interface
Parameters:
- `AW`, 5: address width.
- `DW`, 8: data width.
- `MEM_LAT`, 1: memory read latency in cycles, legal range 1..3.
- `STARVE_MAX`, 4: CPU wait-cycle threshold for forced CPU grant, legal range 1..15.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable; low blocks new arbitration.
- `cpu_req` / `host_req` in 1: access request, level-sensitive.
- `cpu_we` / `host_we` in 1: 1 = write, 0 = read.
- `cpu_addr` / `host_addr` in AW: address.
- `cpu_wdata` / `host_wdata` in DW: write data.
- `cpu_gnt` / `host_gnt` out 1: one-cycle pulse; the access is issued this cycle.
- `cpu_rvalid` / `host_rvalid` out 1: one-cycle pulse; read data valid.
- `cpu_rdata` / `host_rdata` out DW: read data. Both carry `mem_rdata`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid MEM_LAT cycles after `mem_en`.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE, with `ena`=1 and any req high:
  - Register the winner, its `we`, `addr` and `wdata`.
  - Go to ISSUE.
- ISSUE (one cycle):
  - `mem_en`=1; `mem_we`, `mem_addr` and `mem_wdata` are taken from the registered request.
  - Winner's gnt=1.
  - Write: next state IDLE.
  - Read: load the latency counter with MEM_LAT, then go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle it reaches 0, winner's rvalid=1; next state IDLE.
- Priority: host beats CPU when both requests are sampled in the same IDLE cycle.
- Requester obligations:
  - Hold req, we, addr and wdata stable from assertion until the cycle it sees gnt.
  - Drop req the cycle after gnt, or keep it high to request the next access.
- Only one access is outstanding at a time. No new arbitration occurs before the return to IDLE.
- The data outputs are always driven from `mem_rdata`. They are meaningful only with rvalid.
- `ena`=0:
  - IDLE does not arbitrate.
  - An access already in ISSUE/WAIT runs to completion, including its rvalid.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All gnt, rvalid, `mem_en` and `mem_we` outputs go to 0 immediately.
  - An in-flight read is dropped; its rvalid never appears.
  - Starve counter cleared.
- Reset values: every output is 0, except the rdata outputs, which follow `mem_rdata`.

## Timing
- Request latency: req sampled in IDLE at cycle N gives gnt and `mem_en` at N+1.
- Read latency: rvalid at N+1+MEM_LAT.
- Throughput:
  - Write: one every 2 cycles.
  - Read: one every MEM_LAT+2 cycles.
- The starve counter is 4 bits, saturating. It:
  - increments every cycle in which `cpu_req`=1 and `cpu_gnt`=0;
  - clears on `cpu_gnt`.
- A req that rises in ISSUE or WAIT is not seen until the next IDLE cycle.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - When the starve counter is ≥ STARVE_MAX, the next IDLE arbitration grants the CPU even if `host_req`=1.
  - Counter clears on that grant.
- Undefined:
  - No counter logic.
  - Strict host priority; the CPU can starve indefinitely.

## Test plan
- Reset then idle. Assert `rst_n`=0 mid-WAIT of a host read (MEM_LAT=2) -> all gnt, rvalid and `mem_en` go to 0 at once; after release, no rvalid appears.
- CPU write only. `cpu_addr`=5'h03, `cpu_wdata`=8'hA5 at cycle 0 -> `mem_en`=1, `mem_we`=1, `mem_addr`=3, `mem_wdata`=A5 and `cpu_gnt`=1 at cycle 1; then IDLE.
- Host read with MEM_LAT=2, addr 5'h10, memory returning 8'h3C -> `host_gnt` at cycle 1; `host_rvalid`=1 with `host_rdata`=3C at cycle 3; `cpu_rvalid` stays 0.
- Simultaneous requests:
  - Both req high in the same IDLE cycle -> `host_gnt` first.
  - CPU held -> `cpu_gnt` follows once host req is dropped.
- Starvation (macro defined, STARVE_MAX=4):
  - Host req held continuously; CPU req held -> `cpu_gnt` occurs after the counter reaches 4.
  - With the macro undefined -> `cpu_gnt` never occurs.
- `ena` drop. `ena`=0 in the cycle after a CPU read's gnt -> the read still returns rvalid. A pending `host_req` is not granted until `ena`=1.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Two-requester arbiter (CPU, host loader) for a single-port working memory.
// Optional CPU anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module cpu_mem_arbiter #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 8,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] LatInit = 2'(MEM_LAT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e        state_q, state_d;
    logic          host_sel_q, host_sel_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    lat_q, lat_d;
    logic          pick_host;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (cpu_gnt) begin
            starve_d = '0;
        end else if (cpu_req && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // A starved CPU overrides host priority for one arbitration.
    assign pick_host = host_req && !(cpu_req && (starve_q >= 4'(STARVE_MAX)));
`else
    assign pick_host = host_req;
`endif

    always_comb begin
        state_d     = state_q;
        host_sel_d  = host_sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        cpu_gnt     = 1'b0;
        host_gnt    = 1'b0;
        cpu_rvalid  = 1'b0;
        host_rvalid = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ena && (cpu_req || host_req)) begin
                    host_sel_d = pick_host;
                    we_d       = pick_host ? host_we    : cpu_we;
                    addr_d     = pick_host ? host_addr  : cpu_addr;
                    wdata_d    = pick_host ? host_wdata : cpu_wdata;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                mem_en   = 1'b1;
                mem_we   = we_q;
                cpu_gnt  = !host_sel_q;
                host_gnt = host_sel_q;
                if (we_q) begin
                    state_d = StIdle;
                end else begin
                    lat_d   = LatInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                lat_d = lat_q - 2'd1;
                if (lat_q == 2'd1) begin
                    cpu_rvalid  = !host_sel_q;
                    host_rvalid = host_sel_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            host_sel_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            host_sel_q <= host_sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_rdata  = mem_rdata;
    assign host_rdata = mem_rdata;

endmodule
